// File: rtl/serial_sub16_if.sv
// serial_sub16_if: operand/result handshake bundle for the bit-serial subtractor
interface serial_sub16_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero, ovf
    );
endinterface

// File: rtl/serial_sub16.sv
// serial_sub16: bit-serial a - b, one bit per cycle LSB first, with borrow/zero/ovf flags
module serial_sub16 #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    serial_sub16_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sh_q, diff_q;
    logic [IW-1:0]    idx_q;
    logic             br_q, borrow_q, zero_q, ovf_q;
    logic             bit_d, br_d;
    logic [WIDTH-1:0] sh_d;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;

    // one full-subtractor step on the current bit; result bit enters the shift register at the MSB
    always_comb begin
        bit_d = a_q[idx_q] ^ b_q[idx_q] ^ br_q;
        br_d  = (~a_q[idx_q] & b_q[idx_q]) | (~(a_q[idx_q] ^ b_q[idx_q]) & br_q);
        sh_d  = {bit_d, sh_q[WIDTH-1:1]};
    end

    // control FSM; result fields load only on the edge entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            idx_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_q     <= bus.a;
                    b_q     <= bus.b;
                    idx_q   <= '0;
                    br_q    <= 1'b0;
                    state_q <= RUN;
                end
                RUN: begin
                    sh_q  <= sh_d;
                    br_q  <= br_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_q  <= DONE;
                        diff_q   <= sh_d;
                        borrow_q <= br_d;
                        zero_q   <= (sh_d == '0);
                        ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sh_d[WIDTH-1] != a_q[WIDTH-1]);
                    end
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/serial_sub16.md
SERIAL_SUB16 -- requirements
Module: serial_sub16

Interface
REQ-001 Parameter: WIDTH, 16, operand and result width in bits; all requirements below use the default WIDTH=16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  the operand pair on a/b is valid.
REQ-005 in_ready  output  1  the block can accept an operand pair.
REQ-006 a  input  16  minuend.
REQ-007 b  input  16  subtrahend.
REQ-008 out_valid  output  1  the result fields are valid.
REQ-009 out_ready  input  1  the consumer accepts the result.
REQ-010 diff  output  16  a - b, modulo 2^16.
REQ-011 borrow  output  1  unsigned a < b.
REQ-012 zero  output  1  diff == 0.
REQ-013 ovf  output  1  signed (two's-complement) overflow of a - b.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be decoded from state only.
REQ-016 In IDLE, in_valid=1 at a rising edge SHALL do four things: capture a and b into internal registers, clear the bit index to 0, clear the running borrow to 0, and go to RUN.
REQ-017 In RUN, each cycle SHALL process one bit i, LSB first:
- diff[i] = a[i] ^ b[i] ^ br
- br_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br)
REQ-018 RUN SHALL take exactly 16 cycles; after bit 15, the next state SHALL be DONE.
REQ-019 The output fields SHALL be set on entry to DONE:
- borrow = final br
- zero = (diff == 0)
- ovf = (a[15] != b[15]) & (diff[15] != a[15])
REQ-020 Latency: if the handshake completes at edge k, out_valid SHALL be 1 after edge k+16.
REQ-021 In DONE, out_valid=1 and out_ready=1 at an edge SHALL return the FSM to IDLE; in_ready SHALL be 1 in the following cycle.
REQ-022 In DONE with out_ready=0, diff, borrow, zero and ovf SHALL hold stable indefinitely.
REQ-023 in_valid, a and b SHALL be ignored in RUN and DONE; captured operands SHALL NOT change mid-operation.
REQ-024 Changes on a/b after capture SHALL NOT affect the result.
REQ-025 Back-to-back accept is not supported: minimum spacing between accepts is 18 cycles (1 IDLE + 16 RUN + 1 DONE).
REQ-026 out_ready while not in DONE SHALL have no effect.
REQ-027 diff, borrow, zero and ovf SHALL change only on the edge that enters DONE or on reset; the partial diff SHALL be built in an internal shift register.
REQ-028 Operands are unsigned for borrow and two's-complement for ovf; no other width extension SHALL apply.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge:
- force IDLE
- clear the bit index, running borrow and operand registers
- set diff=0, borrow=0, zero=0, ovf=0
REQ-030 Reset values: in_ready=1 and out_valid=0 while rst_n=0 and in the first cycle after release.
REQ-031 Reset asserted in RUN or DONE SHALL abort the operation; no result SHALL be presented.
REQ-032 After rst_n rises, the first accept SHALL be possible at the next rising edge.

Verification
REQ-033 a=0x1080, b=0x0001 accepted -> out_valid 16 cycles later; diff=0x107F, borrow=0, zero=0, ovf=0.
REQ-034 a=0x0001, b=0xFFFB (-5) -> diff=0x0006, borrow=1, ovf=0; then a=0x0001, b=0x0005 -> diff=0xFFFC, borrow=1, ovf=0.
REQ-035 a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1; a=0x0005, b=0x0005 -> diff=0x0000, zero=1, borrow=0.
REQ-036 Result 0x107F held with out_ready=0 for 5 cycles -> outputs stable and out_valid=1 throughout; out_ready=1 -> IDLE and in_ready=1 the next cycle.
REQ-037 in_valid with new a/b pulsed during RUN -> ignored, original result unchanged.
REQ-038 rst_n=0 at RUN bit 7 -> immediate IDLE with outputs 0 and no out_valid; a fresh accept after release completes normally.
